// File: rtl/phase_sel.sv
// Oversampled clock/data recovery phase selector: finds the data edge in each
// UI and steers the 8:1 data mux select toward the eye centre with vote filtering.
//
// state    | meaning
// ACQUIRE  | waiting for the first usable edge to seed select
// TRACK    | voting early/late errors, stepping select, tracking lock
module phase_sel #(
  parameter int VOTE_LIMIT = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] samples,
  output logic [2:0] select,
  output logic       locked,
  output logic       state
);

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_TRACK   = 1'b1;

  localparam logic signed [4:0] VL_POS = 5'(VOTE_LIMIT);
  localparam logic signed [4:0] VL_NEG = -VL_POS;
  localparam logic [7:0]        LC     = 8'(LOCK_COUNT);

  logic              prev;
  logic              prev_valid;
  logic [7:0]        edges;
  logic              usable;
  logic [2:0]        e_pos;
  logic [2:0]        err;
  logic              err_pos;
  logic              err_neg;
  logic signed [4:0] vote;
  logic signed [4:0] vote_upd;
  logic [7:0]        lock_rem;
  logic              step_up;
  logic              step_dn;

  always_comb begin
    edges[0]   = prev_valid & (samples[0] ^ prev);
    edges[7:1] = samples[7:1] ^ samples[6:0];
    usable     = valid && $onehot(edges);
    e_pos      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (edges[i]) e_pos = 3'(i);
    end
  end

  // err wraps mod 8 and reads as signed: 1..3 late, 5..7 early, 4 ambiguous
  always_comb begin
    err      = e_pos - (select + 3'd4);
    err_pos  = (err != 3'd0) && !err[2];
    err_neg  = err[2] && (err[1:0] != 2'd0);
    vote_upd = vote;
    if (err_pos)      vote_upd = vote + 5'sd1;
    else if (err_neg) vote_upd = vote - 5'sd1;
    step_up  = (vote_upd == VL_POS);
    step_dn  = (vote_upd == VL_NEG);
  end

  // lock_rem counts remaining zero-error edges down to a terminal count of 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select     <= 3'd0;
      locked     <= 1'b0;
      state      <= ST_ACQUIRE;
      vote       <= 5'sd0;
      lock_rem   <= LC;
      prev       <= 1'b0;
      prev_valid <= 1'b0;
    end else if (valid) begin
      prev       <= samples[7];
      prev_valid <= 1'b1;
      if (usable) begin
        if (state == ST_ACQUIRE) begin
          select   <= e_pos + 3'd4;
          state    <= ST_TRACK;
          vote     <= 5'sd0;
          lock_rem <= LC;
          locked   <= 1'b0;
        end else if (step_up || step_dn) begin
          select   <= step_up ? select + 3'd1 : select - 3'd1;
          vote     <= 5'sd0;
          lock_rem <= LC;
          locked   <= 1'b0;
        end else begin
          vote <= vote_upd;
          if (err == 3'd0) begin
            if (lock_rem != 8'd0) lock_rem <= lock_rem - 8'd1;
            locked <= (lock_rem <= 8'd1);
          end else begin
            lock_rem <= LC;
            locked   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_sel.sv
// Directed bench for phase_sel: acquisition, lock, vote stepping, wraps,
// ignored UIs and asynchronous reset, with hand-computed expectations.
module tb_phase_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] samples;
  logic [2:0] select;
  logic       locked;
  logic       state;

  int tests = 0;
  int fails = 0;

  phase_sel #(.VOTE_LIMIT(4), .LOCK_COUNT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .samples (samples),
    .select  (select),
    .locked  (locked),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_sel, input logic e_lock, input logic e_state);
    chk({tag, ".select"}, 8'(select), 8'(e_sel));
    chk({tag, ".locked"}, 8'(locked), 8'(e_lock));
    chk({tag, ".state"},  8'(state),  8'(e_state));
  endtask

  task automatic ui(input logic [7:0] s);
    valid   = 1'b1;
    samples = s;
    @(posedge clk);
    #1;
    valid   = 1'b0;
  endtask

  task automatic idle();
    valid   = 1'b0;
    samples = 8'hff;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    samples = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // ACQUIRE ignores idle and multi-edge UIs
    samples = 8'b11110000;
    @(posedge clk);
    #1;
    chk_all("acq_idle", 3'd0, 1'b0, 1'b0);
    ui(8'b01010000);
    chk_all("acq_multi", 3'd0, 1'b0, 1'b0);
    // prev is now 0, so edge at 4 only
    ui(8'b11110000);
    chk_all("acquire", 3'd0, 1'b0, 1'b1);
    ui(8'b11110000);
    chk_all("two_edge", 3'd0, 1'b0, 1'b1);

    for (int k = 1; k <= 8; k++) begin
      ui((k % 2 == 1) ? 8'b00001111 : 8'b11110000);
      if (k == 7) chk_all("lock7", 3'd0, 1'b0, 1'b1);
    end
    chk_all("lock8", 3'd0, 1'b1, 1'b1);

    // err=+1 at select 0: four votes step to 1
    ui(8'b00011111);
    chk_all("late1", 3'd0, 1'b0, 1'b1);
    ui(8'b11100000);
    ui(8'b00011111);
    chk_all("late3", 3'd0, 1'b0, 1'b1);
    ui(8'b11100000);
    chk_all("late4", 3'd1, 1'b0, 1'b1);

    // select 1: err=+1 votes interleaved with idle, multi-edge and err=-4 UIs
    ui(8'b00111111);
    idle();
    chk_all("il_idle", 3'd1, 1'b0, 1'b1);
    ui(8'b01010000);
    ui(8'b11111110);
    chk_all("il_m4", 3'd1, 1'b0, 1'b1);
    ui(8'b00111111);
    ui(8'b11000000);
    chk_all("il_v3", 3'd1, 1'b0, 1'b1);
    ui(8'b00111111);
    chk_all("il_v4", 3'd2, 1'b0, 1'b1);

    // wrap downward 0 -> 7, then upward 7 -> 0
    pulse_rst();
    ui(8'b11110000);
    chk_all("reacq0", 3'd0, 1'b0, 1'b1);
    ui(8'b00000111);
    ui(8'b11111000);
    ui(8'b00000111);
    chk_all("early3", 3'd0, 1'b0, 1'b1);
    ui(8'b11111000);
    chk_all("wrap_dn", 3'd7, 1'b0, 1'b1);
    ui(8'b00001111);
    ui(8'b11110000);
    ui(8'b00001111);
    chk_all("up3", 3'd7, 1'b0, 1'b1);
    ui(8'b11110000);
    chk_all("wrap_up", 3'd0, 1'b0, 1'b1);

    // lock at select 5, then asynchronous reset and re-acquire
    pulse_rst();
    ui(8'b11111110);
    chk_all("acq5", 3'd5, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      ui((k % 2 == 1) ? 8'b00000001 : 8'b11111110);
    end
    chk_all("lock5", 3'd5, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ui(8'b11111100);
    chk_all("reacq6", 3'd6, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
